// File: rtl/sdc_pkg.sv
// Shared definitions for the SD controller CPU front end: register offsets,
// the SDC enable magic value and the bus-cycle FSM encoding.
package sdc_pkg;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_DATA_A = 4'h2;
    localparam logic [3:0] REG_STATUS = 4'h3;
    localparam logic [3:0] REG_CMD    = 4'h8;
    localparam logic [3:0] REG_P1     = 4'h9;
    localparam logic [3:0] REG_P2     = 4'hA;
    localparam logic [3:0] REG_P3     = 4'hB;

    localparam logic [7:0] SDC_MAGIC_DEFAULT = 8'h43;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RDWAIT,
        ST_HOLD
    } state_t;

    // Window decode: only the upper 12 address bits select the 16-byte block.
    function automatic logic window_hit(input logic [15:0] addr,
                                        input logic [15:0] base);
        return addr[15:4] == base[15:4];
    endfunction

endpackage

// File: rtl/sdc_bus_if.sv
// 6809 bus front end for the SD controller: turns each E cycle hitting the
// $FF4x window into one read or write strobe and holds $FF40 locally.
module sdc_bus_if
    import sdc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF40,
    parameter logic [7:0]  SDC_MAGIC = SDC_MAGIC_DEFAULT,
    parameter int          RD_LAT    = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] CPU_ADDR,
    input  logic        CPU_RW,
    input  logic [7:0]  CPU_DOUT,
    input  logic        CPU_VMA,
    input  logic        PH_E,
    input  logic        PH_E_END,
    input  logic [7:0]  SDC_READ_DATA,
    output logic [3:0]  ADDRESS,
    output logic [7:0]  SDC_DATA_IN,
    output logic        SDC_WR,
    output logic        SDC_RD,
    output logic        CLK_EN,
    output logic        SDC_EN,
    output logic [7:0]  CTRL_REG,
    output logic [7:0]  CPU_DIN,
    output logic        CPU_DIN_VALID
);

    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg;
    logic [3:0]  address_reg;
    logic [7:0]  data_in_reg;
    logic        wr_reg, wr_next;
    logic        rd_reg, rd_next;
    logic [7:0]  ctrl_reg;
    logic        sdc_en_reg;
    logic [7:0]  cpu_din_reg;
    logic        valid_reg;

    logic        hit;
    logic        start;
    logic        latch_req;
    logic        capture;
    logic        release_req;

    assign hit   = CPU_VMA & window_hit(CPU_ADDR, BASE_ADDR);
    assign start = PH_E & hit;

    always_comb begin
        state_next  = state_reg;
        wr_next     = 1'b0;
        rd_next     = 1'b0;
        latch_req   = 1'b0;
        capture     = 1'b0;
        release_req = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    latch_req = 1'b1;
                    if (CPU_RW) begin
                        rd_next    = 1'b1;
                        state_next = ST_RDWAIT;
                    end else begin
                        wr_next    = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_RDWAIT: begin
                // PH_E_END seen here is deliberately dropped; HOLD waits for the next one.
                if (cnt_reg == CNT_LAST) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (PH_E_END) begin
                    release_req = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 2'd0;
            wr_reg    <= 1'b0;
            rd_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            wr_reg    <= wr_next;
            rd_reg    <= rd_next;
            if (state_reg == ST_RDWAIT)
                cnt_reg <= cnt_reg + 2'd1;
            else
                cnt_reg <= 2'd0;
        end
    end

    // Address and write data only change when a new access is accepted,
    // so they stay frozen through RDWAIT and HOLD.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            address_reg <= 4'h0;
            data_in_reg <= 8'h00;
        end else if (latch_req) begin
            address_reg <= CPU_ADDR[3:0];
            data_in_reg <= CPU_DOUT;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ctrl_reg   <= 8'h00;
            sdc_en_reg <= 1'b0;
        end else begin
            if (latch_req && !CPU_RW && (CPU_ADDR[3:0] == REG_CTRL))
                ctrl_reg <= CPU_DOUT;
            sdc_en_reg <= (ctrl_reg == SDC_MAGIC);
        end
    end

    // $FF40 reads are answered from the local shadow, not the sdc read mux.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cpu_din_reg <= 8'h00;
            valid_reg   <= 1'b0;
        end else begin
            if (capture) begin
                cpu_din_reg <= (address_reg == REG_CTRL) ? ctrl_reg : SDC_READ_DATA;
                valid_reg   <= 1'b1;
            end else if (release_req) begin
                valid_reg   <= 1'b0;
            end
        end
    end

    assign ADDRESS       = address_reg;
    assign SDC_DATA_IN   = data_in_reg;
    assign SDC_WR        = wr_reg;
    assign SDC_RD        = rd_reg;
    assign CLK_EN        = rd_reg;
    assign SDC_EN        = sdc_en_reg;
    assign CTRL_REG      = ctrl_reg;
    assign CPU_DIN       = cpu_din_reg;
    assign CPU_DIN_VALID = valid_reg;

endmodule

// File: tb/tb_sdc_bus_if.sv
// Directed bench for sdc_bus_if: drives E cycles on the falling edge and
// checks strobes, register shadow and read capture with immediate assertions.
module tb_sdc_bus_if;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] CPU_ADDR;
    logic        CPU_RW;
    logic [7:0]  CPU_DOUT;
    logic        CPU_VMA;
    logic        PH_E;
    logic        PH_E_END;
    logic [7:0]  SDC_READ_DATA;
    logic [3:0]  ADDRESS;
    logic [7:0]  SDC_DATA_IN;
    logic        SDC_WR;
    logic        SDC_RD;
    logic        CLK_EN;
    logic        SDC_EN;
    logic [7:0]  CTRL_REG;
    logic [7:0]  CPU_DIN;
    logic        CPU_DIN_VALID;

    int tests = 0;
    int fails = 0;

    int   wr_cnt = 0;
    int   rd_cnt = 0;
    int   ce_cnt = 0;
    int   ce_mismatch = 0;
    int   valid_rise = 0;
    logic valid_d = 1'b0;
    logic [3:0] wr_addr = 4'h0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] model_val;
    logic [7:0] model_alt;
    logic       after_rd = 1'b0;

    sdc_bus_if #(
        .BASE_ADDR (16'hFF40),
        .SDC_MAGIC (8'h43),
        .RD_LAT    (1)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .CPU_ADDR      (CPU_ADDR),
        .CPU_RW        (CPU_RW),
        .CPU_DOUT      (CPU_DOUT),
        .CPU_VMA       (CPU_VMA),
        .PH_E          (PH_E),
        .PH_E_END      (PH_E_END),
        .SDC_READ_DATA (SDC_READ_DATA),
        .ADDRESS       (ADDRESS),
        .SDC_DATA_IN   (SDC_DATA_IN),
        .SDC_WR        (SDC_WR),
        .SDC_RD        (SDC_RD),
        .CLK_EN        (CLK_EN),
        .SDC_EN        (SDC_EN),
        .CTRL_REG      (CTRL_REG),
        .CPU_DIN       (CPU_DIN),
        .CPU_DIN_VALID (CPU_DIN_VALID)
    );

    always #5 CLK = ~CLK;

    // Read-mux model: returns model_val until one clock after SDC_RD, then model_alt.
    always @(posedge CLK) begin
        if (PH_E_END)
            after_rd <= 1'b0;
        else if (SDC_RD)
            after_rd <= 1'b1;
    end
    assign SDC_READ_DATA = after_rd ? model_alt : model_val;

    always @(posedge CLK) begin
        valid_d <= CPU_DIN_VALID;
        if (CPU_DIN_VALID && !valid_d)
            valid_rise <= valid_rise + 1;
        if (SDC_WR) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= ADDRESS;
            wr_data <= SDC_DATA_IN;
        end
        if (SDC_RD)
            rd_cnt <= rd_cnt + 1;
        if (CLK_EN)
            ce_cnt <= ce_cnt + 1;
        if (CLK_EN !== SDC_RD)
            ce_mismatch <= ce_mismatch + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts an E cycle; returns on the falling edge where the strobe is visible.
    task automatic e_start(input logic [15:0] a, input logic rw, input logic [7:0] d,
                           input logic vma, input logic with_end);
        @(negedge CLK);
        CPU_ADDR = a;
        CPU_RW   = rw;
        CPU_DOUT = d;
        CPU_VMA  = vma;
        PH_E     = 1'b1;
        PH_E_END = with_end;
        @(negedge CLK);
        PH_E     = 1'b0;
        PH_E_END = 1'b0;
    endtask

    task automatic e_end();
        PH_E_END = 1'b1;
        @(negedge CLK);
        PH_E_END = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    int w0, r0, c0, v0;

    initial begin
        RESET_N   = 1'b0;
        CPU_ADDR  = 16'h0000;
        CPU_RW    = 1'b1;
        CPU_DOUT  = 8'h00;
        CPU_VMA   = 1'b0;
        PH_E      = 1'b0;
        PH_E_END  = 1'b0;
        model_val = 8'h00;
        model_alt = 8'h00;

        // Reset state
        idle(3);
        chk("reset_ctrl", 32'(CTRL_REG), 32'h00);
        chk("reset_en", 32'(SDC_EN), 32'h0);
        chk("reset_wr", 32'(SDC_WR), 32'h0);
        chk("reset_rd", 32'(SDC_RD), 32'h0);
        chk("reset_valid", 32'(CPU_DIN_VALID), 32'h0);
        chk("reset_addr", 32'(ADDRESS), 32'h0);
        RESET_N = 1'b1;
        idle(2);

        // Control register write enables SDC mode one clock later
        e_start(16'hFF40, 1'b0, 8'h43, 1'b1, 1'b0);
        chk("ctrl_wr_strobe", 32'(SDC_WR), 32'h1);
        chk("ctrl_wr_value", 32'(CTRL_REG), 32'h43);
        chk("ctrl_en_not_yet", 32'(SDC_EN), 32'h0);
        chk("ctrl_wr_addr", 32'(ADDRESS), 32'h0);
        idle(1);
        chk("ctrl_en_set", 32'(SDC_EN), 32'h1);
        chk("ctrl_wr_single", 32'(SDC_WR), 32'h0);
        e_end();
        e_start(16'hFF40, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(1);
        chk("ctrl_clear_value", 32'(CTRL_REG), 32'h00);
        chk("ctrl_en_clear", 32'(SDC_EN), 32'h0);
        e_end();

        // Long E-high write still gives exactly one strobe
        w0 = wr_cnt;
        e_start(16'hFF48, 1'b0, 8'h80, 1'b1, 1'b0);
        idle(6);
        e_end();
        chk("long_e_wr_count", 32'(wr_cnt - w0), 32'd1);
        chk("long_e_wr_addr", 32'(wr_addr), 32'h8);
        chk("long_e_wr_data", 32'(wr_data), 32'h80);
        chk("long_e_en_untouched", 32'(SDC_EN), 32'h0);

        // Read capture stays stable after the read mux moves on
        model_val = 8'h5A;
        model_alt = 8'hA5;
        r0 = rd_cnt;
        e_start(16'hFF4B, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("rd_strobe", 32'(SDC_RD), 32'h1);
        chk("rd_clk_en", 32'(CLK_EN), 32'h1);
        chk("rd_addr", 32'(ADDRESS), 32'hB);
        idle(1);
        chk("rd_valid", 32'(CPU_DIN_VALID), 32'h1);
        chk("rd_data", 32'(CPU_DIN), 32'h5A);
        idle(4);
        chk("rd_data_stable", 32'(CPU_DIN), 32'h5A);
        chk("rd_valid_held", 32'(CPU_DIN_VALID), 32'h1);
        e_end();
        chk("rd_valid_cleared", 32'(CPU_DIN_VALID), 32'h0);
        chk("rd_count", 32'(rd_cnt - r0), 32'd1);

        // $FF40 read comes from the shadow register
        e_start(16'hFF40, 1'b0, 8'h5C, 1'b1, 1'b0);
        e_end();
        model_val = 8'hEE;
        model_alt = 8'hEE;
        r0 = rd_cnt;
        e_start(16'hFF40, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("ctrl_rd_strobe", 32'(SDC_RD), 32'h1);
        idle(1);
        chk("ctrl_rd_data", 32'(CPU_DIN), 32'h5C);
        e_end();
        chk("ctrl_rd_count", 32'(rd_cnt - r0), 32'd1);

        // Back-to-back data port reads
        model_val = 8'h11;
        model_alt = 8'h22;
        r0 = rd_cnt;
        c0 = ce_cnt;
        v0 = valid_rise;
        for (int i = 0; i < 256; i++) begin
            e_start(16'hFF4A, 1'b1, 8'h00, 1'b1, 1'b0);
            idle(1);
            e_end();
        end
        chk("burst_rd_count", 32'(rd_cnt - r0), 32'd256);
        chk("burst_ce_count", 32'(ce_cnt - c0), 32'd256);
        chk("burst_valid_toggles", 32'(valid_rise - v0), 32'd256);
        chk("burst_last_data", 32'(CPU_DIN), 32'h11);

        // Misses: outside the window, or VMA low
        w0 = wr_cnt;
        r0 = rd_cnt;
        e_start(16'hFF50, 1'b1, 8'h00, 1'b1, 1'b0);
        idle(2);
        chk("miss_no_valid", 32'(CPU_DIN_VALID), 32'h0);
        e_end();
        e_start(16'hFF48, 1'b0, 8'h77, 1'b0, 1'b0);
        idle(2);
        e_end();
        chk("miss_wr_count", 32'(wr_cnt - w0), 32'd0);
        chk("miss_rd_count", 32'(rd_cnt - r0), 32'd0);
        e_start(16'hFF48, 1'b0, 8'h66, 1'b1, 1'b0);
        chk("miss_then_hit", 32'(SDC_WR), 32'h1);
        chk("miss_then_hit_data", 32'(SDC_DATA_IN), 32'h66);
        e_end();

        // PH_E with PH_E_END in IDLE, then a stray PH_E during HOLD
        r0 = rd_cnt;
        e_start(16'hFF49, 1'b1, 8'h00, 1'b1, 1'b1);
        chk("overlap_strobe", 32'(SDC_RD), 32'h1);
        idle(3);
        chk("overlap_held", 32'(CPU_DIN_VALID), 32'h1);
        e_start(16'hFF49, 1'b1, 8'h00, 1'b1, 1'b0);
        idle(1);
        chk("hold_pe_ignored", 32'(rd_cnt - r0), 32'd1);
        e_end();
        chk("overlap_release", 32'(CPU_DIN_VALID), 32'h0);

        // Asynchronous reset while in RDWAIT
        e_start(16'hFF40, 1'b0, 8'h43, 1'b1, 1'b0);
        e_end();
        model_val = 8'h3C;
        model_alt = 8'hC3;
        e_start(16'hFF4A, 1'b1, 8'h00, 1'b1, 1'b0);
        RESET_N = 1'b0;
        #1;
        chk("arst_rd", 32'(SDC_RD), 32'h0);
        chk("arst_clk_en", 32'(CLK_EN), 32'h0);
        chk("arst_ctrl", 32'(CTRL_REG), 32'h00);
        chk("arst_en", 32'(SDC_EN), 32'h0);
        chk("arst_addr", 32'(ADDRESS), 32'h0);
        chk("arst_din", 32'(CPU_DIN), 32'h00);
        chk("arst_data_in", 32'(SDC_DATA_IN), 32'h00);
        chk("arst_valid", 32'(CPU_DIN_VALID), 32'h0);
        idle(2);
        RESET_N = 1'b1;
        w0 = wr_cnt;
        r0 = rd_cnt;
        idle(4);
        chk("post_rst_no_rd", 32'(rd_cnt - r0), 32'd0);
        chk("post_rst_no_wr", 32'(wr_cnt - w0), 32'd0);
        chk("post_rst_no_valid", 32'(CPU_DIN_VALID), 32'h0);
        e_start(16'hFF4A, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("post_rst_rd", 32'(SDC_RD), 32'h1);
        idle(1);
        chk("post_rst_data", 32'(CPU_DIN), 32'h3C);
        e_end();

        chk("clk_en_tracks_rd", 32'(ce_mismatch), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
